mem_reinit_ctrl: RTL and testbench

MEM_REINIT_CTRL -- requirements
Module: mem_reinit_ctrl

---
 rtl/mem_reinit_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_reinit_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reinit_ctrl.sv
// Memory re-initialisation engine: streams a full fill or dump of an external
// synchronous RAM and otherwise passes user reads/writes through while idle.
//   state   | meaning
//   ST_IDLE | user port owns the memory; commands accepted
//   ST_FILL | in_* stream written to addresses 0..DEPTH_MEM-1
//   ST_DUMP | addresses 0..DEPTH_MEM-1 read out through a 2-entry FIFO
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 36,
  parameter int DEPTH_MEM = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_fill,
  input  logic               cmd_dump,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WID_MEM-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WID_MEM-1:0] out_data,
  input  logic               usr_we,
  input  logic [31:0]        usr_waddr,
  input  logic [WID_MEM-1:0] usr_din,
  input  logic               usr_re,
  input  logic [31:0]        usr_raddr,
  output logic               usr_rvalid,
  output logic [WID_MEM-1:0] usr_dout,
  output logic [15:0]        drop_cnt,
  output logic               mem_we,
  output logic [31:0]        mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic [31:0]        mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout
);

  localparam int            PW        = $clog2(DEPTH_MEM) + 1;
  localparam logic [PW-1:0] LAST_ADDR = PW'(DEPTH_MEM - 1);
  localparam logic [31:0]   DEPTH_32  = 32'(DEPTH_MEM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      pop_ptr_q, pop_ptr_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         fifo_cnt_q, fifo_cnt_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic [WID_MEM-1:0] fifo_q [2];
  logic [WID_MEM-1:0] fifo_d [2];
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               usr_rvalid_q, usr_rvalid_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic               usr_in_range;
  logic               fill_wr;
  logic               pop;
  logic               rd_issue;
  logic               usr_drop;
  logic               leave;
  logic [2:0]         occ;

  // A read may issue only if the word it returns is guaranteed a FIFO slot.
  always_comb begin
    usr_in_range = (usr_waddr < DEPTH_32);
    fill_wr      = (state_q == ST_FILL) && in_valid;
    pop          = (fifo_cnt_q != 2'd0) && out_ready;
    occ          = 3'(fifo_cnt_q) + 3'(inflight_q);
    rd_issue     = (state_q == ST_DUMP) && (rd_ptr_q <= LAST_ADDR) &&
                   (occ < (3'd2 + 3'(pop)));
    usr_drop     = usr_we && ((state_q != ST_IDLE) || !usr_in_range);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fill_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      pop_ptr_q    <= '0;
      inflight_q   <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      usr_rvalid_q <= 1'b0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      fill_ptr_q   <= fill_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pop_ptr_q    <= pop_ptr_d;
      inflight_q   <= inflight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      usr_rvalid_q <= usr_rvalid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q[0] <= fifo_d[0];
    fifo_q[1] <= fifo_d[1];
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fill) begin
          state_d = ST_FILL;
        end else if (cmd_dump) begin
          state_d = ST_DUMP;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (fill_wr && (fill_ptr_q == LAST_ADDR)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_DUMP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (pop && (pop_ptr_q == LAST_ADDR)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    leave        = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    fill_ptr_d   = fill_ptr_q + PW'(fill_wr);
    rd_ptr_d     = rd_ptr_q + PW'(rd_issue);
    pop_ptr_d    = pop_ptr_q + PW'(pop);
    inflight_d   = rd_issue;
    fifo_cnt_d   = fifo_cnt_q + 2'(inflight_q) - 2'(pop);
    fifo_wr_d    = fifo_wr_q ^ inflight_q;
    fifo_rd_d    = fifo_rd_q ^ pop;
    fifo_d[0]    = fifo_q[0];
    fifo_d[1]    = fifo_q[1];
    if (inflight_q) begin
      fifo_d[fifo_wr_q] = mem_dout;
    end
    if (leave) begin
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      pop_ptr_d  = '0;
      inflight_d = 1'b0;
      fifo_cnt_d = 2'd0;
      fifo_wr_d  = 1'b0;
      fifo_rd_d  = 1'b0;
    end
    usr_rvalid_d = usr_re && (state_q == ST_IDLE);
    drop_cnt_d   = drop_cnt_q;
    if (usr_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    in_ready   = (state_q == ST_FILL);
    out_valid  = (fifo_cnt_q != 2'd0);
    out_data   = fifo_q[fifo_rd_q];
    done       = done_q;
    aborted    = aborted_q;
    usr_rvalid = usr_rvalid_q;
    usr_dout   = mem_dout;
    drop_cnt   = drop_cnt_q;
    mem_we     = fill_wr || ((state_q == ST_IDLE) && usr_we && usr_in_range);
    mem_waddr  = usr_waddr;
    mem_din    = usr_din;
    mem_raddr  = usr_raddr;
    if (state_q == ST_FILL) begin
      mem_waddr = 32'(fill_ptr_q);
      mem_din   = in_data;
    end
    if (state_q == ST_DUMP) begin
      mem_raddr = 32'(rd_ptr_q);
    end
  end

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Bench for mem_reinit_ctrl: a registered-read RAM model plus a reference
// image of what the memory must hold, driven with randomised streams.
module tb_mem_reinit_ctrl;

  localparam int WID   = 36;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cmd_fill, cmd_dump, abort;
  logic              busy, done, aborted;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [WID-1:0]    in_data, out_data;
  logic              usr_we, usr_re, usr_rvalid;
  logic [31:0]       usr_waddr, usr_raddr;
  logic [WID-1:0]    usr_din, usr_dout;
  logic [15:0]       drop_cnt;
  logic              mem_we;
  logic [31:0]       mem_waddr, mem_raddr;
  logic [WID-1:0]    mem_din, mem_dout;

  mem_reinit_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_fill(cmd_fill), .cmd_dump(cmd_dump),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_din(usr_din),
    .usr_re(usr_re), .usr_raddr(usr_raddr), .usr_rvalid(usr_rvalid),
    .usr_dout(usr_dout), .drop_cnt(drop_cnt), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_raddr(mem_raddr),
    .mem_dout(mem_dout)
  );

  // The RAM the controller talks to: write on mem_we, dout one cycle after raddr.
  logic [WID-1:0] bmem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) bmem[mem_waddr[AW-1:0]] <= mem_din;
    mem_dout <= bmem[mem_raddr[AW-1:0]];
  end

  logic [WID-1:0] ref_mem [DEPTH];
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  function automatic logic [WID-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[WID-1:0];
  endfunction

  function automatic logic [WID-1:0] pat(input int a);
    logic [31:0] t;
    t = 32'(a) ^ 32'hA5;
    return WID'(t);
  endfunction

  task automatic do_fill(input bit gaps, input bit rnd_data, input int n_usr, input int stop_at);
    int ptr;
    int cyc;
    bit v;
    logic [WID-1:0] w;
    ptr = 0;
    cyc = 0;
    @(negedge clk); cmd_fill = 1'b1;
    @(negedge clk); cmd_fill = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fill_entry: busy=%b in_ready=%b, need 1 1", busy, in_ready);
    end
    while (ptr < stop_at && cyc < 20000) begin
      v = !gaps || ($urandom_range(0, 3) != 0);
      w = rnd_data ? rnd_word() : pat(ptr);
      in_valid  = v;
      in_data   = w;
      usr_we    = (cyc < n_usr);
      usr_waddr = 32'($urandom_range(0, DEPTH - 1));
      usr_din   = rnd_word();
      if (usr_we) exp_drop++;
      #1;
      checks++;
      if (mem_we !== v || in_ready !== 1'b1 || done !== 1'b0 ||
          (v && (mem_waddr !== 32'(ptr) || mem_din !== w))) begin
        errors++;
        $display("FAIL fill_write: we=%b addr=%0d din=%h ready=%b done=%b, need we=%b addr=%0d din=%h ready=1 done=0",
                 mem_we, mem_waddr, mem_din, in_ready, done, v, ptr, w);
      end
      @(negedge clk);
      if (v) begin
        ref_mem[ptr] = w;
        ptr++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    usr_we   = 1'b0;
    if (cyc >= 20000) begin
      errors++; $display("FAIL fill_timeout: wrote %0d words, need %0d", ptr, stop_at);
    end
    if (stop_at == DEPTH) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL fill_done: done=%b busy=%b in_ready=%b, need 1 0 0", done, busy, in_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL fill_done_pulse: done=%b, need 0", done);
      end
    end
  endtask

  // mode 0: out_ready held high; 1: out_ready random; 2: stall at word 500 then abort
  task automatic do_dump(input int mode);
    int idx;
    int cyc;
    int busy_cyc;
    bit hold;
    bit rdy;
    logic [WID-1:0] held;
    idx = 0; cyc = 0; busy_cyc = 0; hold = 1'b0; held = '0;
    @(negedge clk); cmd_dump = 1'b1;
    @(negedge clk); cmd_dump = 1'b0;
    while (cyc < 20000) begin
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL dump_hold: valid=%b data=%h, need 1 %h", out_valid, out_data, held);
        end
      end
      if (done) break;
      if (mode == 2 && idx == 500 && out_valid) break;
      if (busy) busy_cyc++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) == 1);
        default: rdy = (idx < 500);
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        checks++;
        if (idx >= DEPTH || out_data !== ref_mem[idx[AW-1:0]]) begin
          errors++; $display("FAIL dump_data: word %0d got %h, need %h", idx, out_data, ref_mem[idx[AW-1:0]]);
        end
        idx++;
      end
      hold = out_valid && !rdy;
      held = out_data;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 20000) begin
      errors++; $display("FAIL dump_timeout: popped %0d words", idx);
    end
    if (mode != 2) begin
      checks++;
      if (idx !== DEPTH || busy !== 1'b0) begin
        errors++; $display("FAIL dump_count: popped %0d busy=%b, need %0d 0", idx, busy, DEPTH);
      end
      if (mode == 0) begin
        checks++;
        if (busy_cyc !== DEPTH + 2) begin
          errors++; $display("FAIL dump_cycles: busy for %0d cycles, need %0d", busy_cyc, DEPTH + 2);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL dump_done_pulse: done=%b valid=%b, need 0 0", done, out_valid);
      end
    end else begin
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref_mem[500] || done !== 1'b0) begin
          errors++; $display("FAIL abort_stall: valid=%b data=%h done=%b, need 1 %h 0", out_valid, out_data, done, ref_mem[500]);
        end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL abort_dump: busy=%b valid=%b aborted=%b done=%b, need 0 0 1 0", busy, out_valid, aborted, done);
      end
      @(negedge clk);
      checks++;
      if (aborted !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL abort_pulse: aborted=%b done=%b, need 0 0", aborted, done);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({busy, done, aborted, in_ready, out_valid, usr_rvalid, mem_we} !== 7'b0) begin
      errors++; $display("FAIL %s_outputs: busy,done,aborted,in_ready,out_valid,rvalid,we=%b, need 0000000", tag,
                         {busy, done, aborted, in_ready, out_valid, usr_rvalid, mem_we});
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL %s_drop_cnt: %0d, need 0", tag, drop_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");
  endtask

  task automatic test_fill();
    do_fill(1'b0, 1'b0, 0, DEPTH);
  endtask

  task automatic test_dump_backpressure();
    do_dump(1);
  endtask

  task automatic test_contention();
    do_fill(1'b1, 1'b0, 10, DEPTH);
    usr_we    = 1'b1;
    usr_waddr = 32'd2000;
    usr_din   = rnd_word();
    exp_drop++;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL oob_write: mem_we=%b, need 0", mem_we);
    end
    @(negedge clk);
    usr_we = 1'b0;
    checks++;
    if (drop_cnt !== 16'(exp_drop) || exp_drop != 11) begin
      errors++; $display("FAIL drop_cnt: got %0d, need %0d (model %0d)", drop_cnt, 11, exp_drop);
    end
  endtask

  task automatic test_abort_dump();
    do_dump(2);
  endtask

  task automatic test_dump_full();
    do_dump(0);
  endtask

  task automatic test_simul_cmds();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: aborted=%b busy=%b, need 0 0", aborted, busy);
    end
    cmd_fill = 1'b1;
    cmd_dump = 1'b1;
    @(negedge clk);
    cmd_fill = 1'b0;
    cmd_dump = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL simul_cmds: busy=%b in_ready=%b out_valid=%b, need 1 1 0", busy, in_ready, out_valid);
    end
    usr_re    = 1'b1;
    usr_raddr = 32'd5;
    @(negedge clk);
    usr_re = 1'b0;
    checks++;
    if (usr_rvalid !== 1'b0) begin
      errors++; $display("FAIL busy_read: usr_rvalid=%b, need 0", usr_rvalid);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_fill: aborted=%b busy=%b done=%b in_ready=%b, need 1 0 0 0", aborted, busy, done, in_ready);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_fill(1'b0, 1'b1, 0, 300);
    reset    = 1'b1;
    abort    = 1'b1;
    cmd_fill = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    abort    = 1'b0;
    cmd_fill = 1'b0;
    exp_drop = 0;
    check_reset_outputs("mid_fill_reset");
    do_fill(1'b0, 1'b1, 0, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL refill_abort: aborted=%b busy=%b, need 1 0", aborted, busy);
    end
  endtask

  task automatic test_user_rw();
    int wa;
    int ra;
    logic [WID-1:0] wd;
    for (int i = 0; i < 16; i++) begin
      wa = $urandom_range(0, DEPTH - 1);
      wd = rnd_word();
      usr_we    = 1'b1;
      usr_waddr = 32'(wa);
      usr_din   = wd;
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_waddr !== 32'(wa) || mem_din !== wd) begin
        errors++; $display("FAIL usr_write: we=%b addr=%0d din=%h, need 1 %0d %h", mem_we, mem_waddr, mem_din, wa, wd);
      end
      @(negedge clk);
      usr_we = 1'b0;
      ref_mem[wa] = wd;
      ra = (i % 4 == 0) ? wa : $urandom_range(0, DEPTH - 1);
      usr_re    = 1'b1;
      usr_raddr = 32'(ra);
      @(negedge clk);
      usr_re = 1'b0;
      checks++;
      if (usr_rvalid !== 1'b1 || usr_dout !== ref_mem[ra]) begin
        errors++; $display("FAIL usr_read: addr %0d rvalid=%b dout=%h, need 1 %h", ra, usr_rvalid, usr_dout, ref_mem[ra]);
      end
      @(negedge clk);
      checks++;
      if (usr_rvalid !== 1'b0) begin
        errors++; $display("FAIL usr_rvalid_pulse: rvalid=%b, need 0", usr_rvalid);
      end
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++; $display("FAIL drop_cnt_final: got %0d, need %0d", drop_cnt, exp_drop);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_fill = 1'b0; cmd_dump = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    usr_we = 1'b0; usr_waddr = '0; usr_din = '0; usr_re = 1'b0; usr_raddr = '0;
    test_reset();
    test_fill();
    test_dump_backpressure();
    test_contention();
    test_abort_dump();
    test_dump_full();
    test_simul_cmds();
    test_reset_mid_fill();
    test_user_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
